// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants for the multi-cycle issue controller: datapath width, operation
// codes, default multiply latency and the controller state encoding.
package mul_issue_ctrl_pkg;

  localparam int DEF_WORD_SIZE   = 32;
  localparam int DEF_MUL_LATENCY = 5;
  localparam int CNT_W           = 3;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b001;
  localparam logic [2:0] F3_AND = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b011;
  localparam logic [2:0] F3_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic funct3_legal(input logic [2:0] f3);
    case (f3)
      F3_ADD, F3_SUB, F3_AND, F3_OR, F3_MUL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Decode, ALU and writeback signals of the issue controller bundled as one interface;
// slave is the controller's view, master the surrounding pipeline's view.
interface mul_issue_ctrl_if
  import mul_issue_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
);

  logic                 id_valid;
  logic [2:0]           id_funct3;
  logic [WORD_SIZE-1:0] id_a;
  logic [WORD_SIZE-1:0] id_b;
  logic [4:0]           id_rd;
  logic                 flush;
  logic                 stallD;
  logic [2:0]           alu_ctrl;
  logic [WORD_SIZE-1:0] alu_a;
  logic [WORD_SIZE-1:0] alu_b;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 wb_zero;

  modport slave (
    input  id_valid, id_funct3, id_a, id_b, id_rd, flush, alu_result,
    output stallD, alu_ctrl, alu_a, alu_b, wb_valid, wb_rd, wb_data, wb_zero
  );

  modport master (
    output id_valid, id_funct3, id_a, id_b, id_rd, flush, alu_result,
    input  stallD, alu_ctrl, alu_a, alu_b, wb_valid, wb_rd, wb_data, wb_zero
  );

endinterface

// File: rtl/mul_issue_ctrl_lat_counter.sv
// Loadable down-counter that times how long an issued operation occupies the ALU.
// Decrement saturates at zero so a stray decrement can never wrap around.
module lat_counter
  import mul_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // next count: clear beats load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == 3'd0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for a shared ALU: accepts one decoded operation at a time, holds the
// ALU operands for the operation's latency, then presents a one-cycle writeback.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  mul_issue_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY);

  state_e               state_d, state_q;
  logic [2:0]           alu_ctrl_d, alu_ctrl_q;
  logic [WORD_SIZE-1:0] alu_a_d, alu_a_q;
  logic [WORD_SIZE-1:0] alu_b_d, alu_b_q;
  logic [4:0]           tag_d, tag_q;
  logic [WORD_SIZE-1:0] wb_data_d, wb_data_q;
  logic                 wb_valid_d, wb_valid_q;
  logic [4:0]           wb_rd_d, wb_rd_q;
  logic                 wb_zero_d, wb_zero_q;
  logic                 stall_d, stall_q;

  logic                 accept;
  logic                 capture;
  logic                 cnt_clr;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_load_val;
  logic [CNT_W-1:0]     cnt_value;
  logic                 cnt_zero;
  logic                 req_ok;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  assign req_ok = bus.id_valid && !bus.flush && funct3_legal(bus.id_funct3);

  // next state and counter control
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = (bus.id_funct3 == F3_MUL) ? MUL_LOAD : 3'd1;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          // an empty counter while busy can only be corruption; drop the operation
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_value == 3'd1) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_DONE: begin
        if (req_ok) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // operand, tag and writeback next values
  always_comb begin
    if (accept) begin
      alu_ctrl_d = bus.id_funct3;
      alu_a_d    = bus.id_a;
      alu_b_d    = bus.id_b;
      tag_d      = bus.id_rd;
    end else begin
      alu_ctrl_d = alu_ctrl_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      tag_d      = tag_q;
    end
    if (capture) begin
      wb_data_d = bus.alu_result;
    end else begin
      wb_data_d = wb_data_q;
    end
    // writeback lands one edge after the DONE cycle unless that cycle is flushed
    wb_valid_d = (state_q == ST_DONE) && !bus.flush;
    if (wb_valid_d) begin
      wb_rd_d   = tag_q;
      wb_zero_d = (wb_data_q == {WORD_SIZE{1'b0}});
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_zero_d = wb_zero_q;
    end
    stall_d = (state_d == ST_BUSY);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      alu_ctrl_q <= F3_ADD;
      alu_a_q    <= {WORD_SIZE{1'b0}};
      alu_b_q    <= {WORD_SIZE{1'b0}};
      tag_q      <= 5'd0;
      wb_data_q  <= {WORD_SIZE{1'b0}};
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_zero_q  <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      tag_q      <= tag_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_zero_q  <= wb_zero_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.stallD   = stall_q;
  assign bus.alu_ctrl = alu_ctrl_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_zero  = wb_zero_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: a timeline model predicts stall, ALU drive and
// writeback every cycle, and hand-computed literals pin the key scenarios.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mul_issue_ctrl_if #(.WORD_SIZE(W)) bus();

  mul_issue_ctrl #(.WORD_SIZE(W), .MUL_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU: a multiply result is only valid once the operands have been steady
  // for LAT edges; before that it returns junk.
  int          alu_age = 0;
  logic [2:0]  last_c  = 3'b000;
  logic [31:0] last_a  = 32'd0;
  logic [31:0] last_b  = 32'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.alu_ctrl !== last_c || bus.alu_a !== last_a || bus.alu_b !== last_b) begin
        alu_age = 0;
        last_c  = bus.alu_ctrl;
        last_a  = bus.alu_a;
        last_b  = bus.alu_b;
      end else if (alu_age < 1000) begin
        alu_age++;
      end
    end
  end

  always_comb begin
    bus.alu_result = calc(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    if (bus.alu_ctrl == 3'b100 && alu_age < LAT - 1) bus.alu_result = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: an op accepted at edge n is busy for lat cycles, sits one cycle in
  // DONE, and its writeback is visible in the cycle after edge n+lat+1.
  int          edge_n;
  bit          m_act;
  int          m_until;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  bit          e_wb, e_stall;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  logic [2:0]  e_ctrl;
  logic [31:0] e_a, e_b;

  task automatic model_reset();
    edge_n = 0; m_act = 1'b0; m_until = 0; m_rd = 5'd0; m_res = 32'd0;
    e_wb = 1'b0; e_stall = 1'b0; e_rd = 5'd0; e_data = 32'd0;
    e_ctrl = 3'b000; e_a = 32'd0; e_b = 32'd0;
  endtask

  task automatic model_edge();
    bit busy_c, done_c;
    busy_c = m_act && (edge_n < m_until);
    done_c = m_act && (edge_n == m_until);
    edge_n++;
    e_wb = 1'b0;
    if (bus.flush) begin
      if (busy_c || done_c) m_act = 1'b0;
    end else begin
      if (done_c) begin
        e_wb = 1'b1; e_rd = m_rd; e_data = m_res; m_act = 1'b0;
      end
      if (!busy_c && bus.id_valid && bus.id_funct3 <= 3'b100) begin
        m_act   = 1'b1;
        m_until = edge_n + ((bus.id_funct3 == 3'b100) ? LAT : 1);
        m_rd    = bus.id_rd;
        m_res   = calc(bus.id_funct3, bus.id_a, bus.id_b);
        e_ctrl  = bus.id_funct3; e_a = bus.id_a; e_b = bus.id_b;
      end
    end
    e_stall = m_act && (edge_n < m_until);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_edge();
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_stall", bus.stallD, e_stall);
      chk("m_wb_valid", bus.wb_valid, e_wb);
      chk("m_alu_ctrl", bus.alu_ctrl, e_ctrl);
      chk("m_alu_a", bus.alu_a, e_a);
      chk("m_alu_b", bus.alu_b, e_b);
      if (e_wb) begin
        chk("m_wb_rd", bus.wb_rd, e_rd);
        chk("m_wb_data", bus.wb_data, e_data);
        chk("m_wb_zero", bus.wb_zero, (e_data == 32'd0));
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic fl);
    bus.id_valid = v; bus.id_funct3 = f; bus.id_a = a; bus.id_b = b;
    bus.id_rd = rd; bus.flush = fl;
  endtask

  task automatic tick(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic fl);
    @(posedge clk); #2;
    drive(v, f, a, b, rd, fl);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_stall"}, bus.stallD, 32'd0);
    chk({tag, "_wbv"}, bus.wb_valid, 32'd0);
    chk({tag, "_zero"}, bus.wb_zero, 32'd0);
    chk({tag, "_rd"}, bus.wb_rd, 32'd0);
    chk({tag, "_data"}, bus.wb_data, 32'd0);
    chk({tag, "_ctrl"}, bus.alu_ctrl, 32'd0);
    chk({tag, "_a"}, bus.alu_a, 32'd0);
    chk({tag, "_b"}, bus.alu_b, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 rst = 1'b0;
    #1 reset_lits("por");
    repeat (2) @(posedge clk);

    // ADD presented together with reset release: accepted on the first edge
    @(posedge clk); #2;
    rst = 1'b1;
    drive(1'b1, 3'b000, 32'd5, 32'd7, 5'd3, 1'b0);
    @(negedge clk);
    idle(); chk("add_stall_e0", bus.stallD, 32'd1);
    idle(); chk("add_stall_e1", bus.stallD, 32'd0); chk("add_wb_e1", bus.wb_valid, 32'd0);
    idle(); chk("add_wb_e2", bus.wb_valid, 32'd1); chk("add_data", bus.wb_data, 32'd12);
    chk("add_rd", bus.wb_rd, 32'd3); chk("add_zero", bus.wb_zero, 32'd0);
    idle(); chk("add_wb_e3", bus.wb_valid, 32'd0);

    // MUL with the next op held on the decode bus through the stall
    tick(1'b1, 3'b100, 32'd6, 32'd7, 5'd9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 3'b000, 32'd1, 32'd2, 5'd4, 1'b0);
      chk("mul_stall", bus.stallD, (i < 5) ? 32'd1 : 32'd0);
      chk("mul_wb_early", bus.wb_valid, 32'd0);
    end
    idle(); chk("mul_wb", bus.wb_valid, 32'd1); chk("mul_data", bus.wb_data, 32'd42);
    chk("mul_rd", bus.wb_rd, 32'd9); chk("held_add_stall", bus.stallD, 32'd1);
    idle(); idle(); chk("held_add_wb", bus.wb_valid, 32'd1); chk("held_add_data", bus.wb_data, 32'd3);

    // SUB to zero, then MUL presented in its DONE cycle
    tick(1'b1, 3'b001, 32'd4, 32'd4, 5'd5, 1'b0);
    idle(); chk("sub_stall", bus.stallD, 32'd1);
    tick(1'b1, 3'b100, 32'd3, 32'd5, 5'd6, 1'b0); chk("sub_done_stall", bus.stallD, 32'd0);
    idle(); chk("sub_wb", bus.wb_valid, 32'd1); chk("sub_data", bus.wb_data, 32'd0);
    chk("sub_zero", bus.wb_zero, 32'd1); chk("b2b_stall", bus.stallD, 32'd1);
    n = 0; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      idle(); n++;
      if (bus.wb_valid === 1'b1) found = 1'b1;
    end
    chk("b2b_found", found, 32'd1); chk("b2b_lat", n, 32'd6);
    chk("b2b_data", bus.wb_data, 32'd15); chk("b2b_rd", bus.wb_rd, 32'd6);

    // AND
    tick(1'b1, 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd17, 1'b0);
    idle(); idle(); idle(); chk("and_data", bus.wb_data, 32'h00F0_1234);

    // flush two cycles into a MUL, then an ADD
    tick(1'b1, 3'b100, 32'd2, 32'd3, 5'd7, 1'b0);
    idle(); idle();
    tick(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b1); chk("fl_stall_before", bus.stallD, 32'd1);
    idle(); chk("fl_stall", bus.stallD, 32'd0); chk("fl_wb", bus.wb_valid, 32'd0);
    tick(1'b1, 3'b000, 32'd10, 32'd20, 5'd1, 1'b0);
    idle(); idle(); idle(); chk("fl_add_wb", bus.wb_valid, 32'd1); chk("fl_add_data", bus.wb_data, 32'd30);

    // flush in the DONE cycle suppresses the writeback
    tick(1'b1, 3'b000, 32'd9, 32'd9, 5'd8, 1'b0);
    idle();
    tick(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b1);
    idle(); chk("fl_done_wb", bus.wb_valid, 32'd0);

    // flush and id_valid together in IDLE: no accept
    tick(1'b1, 3'b000, 32'd1, 32'd1, 5'd2, 1'b1);
    idle(); chk("fl_idle_stall", bus.stallD, 32'd0);
    idle(); idle(); chk("fl_idle_wb", bus.wb_valid, 32'd0);

    // illegal operation codes are consumed silently
    for (int f = 5; f < 8; f++) begin
      tick(1'b1, 3'(f), 32'h55, 32'h66, 5'd3, 1'b0);
      idle(); chk("ill_stall", bus.stallD, 32'd0); chk("ill_alu_a", bus.alu_a, 32'd9);
      idle(); idle(); chk("ill_wb", bus.wb_valid, 32'd0);
    end

    // reset three cycles into a MUL
    tick(1'b1, 3'b100, 32'd6, 32'd6, 5'd10, 1'b0);
    idle(); idle(); idle();
    @(posedge clk); #2;
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 reset_lits("mid_mul");
    repeat (2) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    drive(1'b1, 3'b011, 32'h0000_00A0, 32'h0000_000B, 5'd21, 1'b0);
    @(negedge clk);
    idle(); chk("or_stall", bus.stallD, 32'd1);
    idle(); idle(); chk("or_wb", bus.wb_valid, 32'd1);
    chk("or_data", bus.wb_data, 32'h0000_00AB); chk("or_rd", bus.wb_rd, 32'd21);
    repeat (8) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width, taken from the shared constants.
REQ-002 SHALL have parameter MUL_LATENCY, default 5, number of edges from operand presentation to a valid ALU multiply result.
REQ-003 SHALL have port clk  input  1  single clock; all state on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port id_valid  input  1  decode stage presents an operation.
REQ-006 SHALL have port id_funct3  input  3  operation code: ADD/SUB/AND/OR/MUL per the shared FUNCT3 constants.
REQ-007 SHALL have ports id_a, id_b  input  WORD_SIZE  operands.
REQ-008 SHALL have port id_rd  input  5  destination register tag.
REQ-009 SHALL have port flush  input  1  kills any accepted, not-yet-written-back operation.
REQ-010 SHALL have port stallD  output  1  decode must hold its outputs this cycle.
REQ-011 SHALL have ports alu_ctrl (3), alu_a, alu_b (WORD_SIZE)  output  registered ALU drive.
REQ-012 SHALL have port alu_result  input  WORD_SIZE  ALU output.
REQ-013 SHALL have ports wb_valid (1), wb_rd (5), wb_data (WORD_SIZE), wb_zero (1)  output  writeback.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: id_valid & !flush with legal funct3 SHALL accept at edge E0, register alu_ctrl/alu_a/alu_b/tag, enter BUSY.
REQ-016 Illegal funct3 SHALL be consumed without ALU drive or writeback; state stays IDLE.
REQ-017 SHALL load a 3-bit down-counter at accept: 1 for ADD/SUB/AND/OR, MUL_LATENCY for MUL.
REQ-018 BUSY SHALL decrement the counter each edge; at the edge where it reaches 0, SHALL capture alu_result into wb_data and enter DONE.
REQ-019 Single-cycle op: wb_valid SHALL be high in the cycle after edge E0+2; MUL: after edge E0+1+MUL_LATENCY.
REQ-020 DONE SHALL assert wb_valid, wb_rd=tag, wb_zero=(wb_data==0) for exactly one cycle, then return to IDLE, or accept a new request in that same cycle (back-to-back).
REQ-021 stallD SHALL be high in every BUSY cycle and low in IDLE and DONE.
REQ-022 alu_ctrl/alu_a/alu_b SHALL stay constant from accept until the capture edge.
REQ-023 id_valid during BUSY SHALL be ignored (stall held).
REQ-024 flush in BUSY or DONE SHALL force IDLE at the next edge, suppress wb_valid, clear stallD.
REQ-025 flush and id_valid in the same IDLE cycle: flush wins, no accept.

Reset
REQ-026 rst low SHALL immediately force IDLE, counter 0, stallD 0, wb_valid 0, wb_zero 0, wb_rd 0, wb_data 0, alu_ctrl=ADD code, alu_a 0, alu_b 0.
REQ-027 Reset mid-MUL SHALL discard the operation; no writeback after release.
REQ-028 First accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-029 WORD_SIZE, FUNCT3 codes and MUL_LATENCY default SHALL live in the shared constants file.
REQ-030 The FSM state encoding SHALL be defined once in the shared constants file.
REQ-031 The latency counter SHALL be a sub-module, lat_counter (load, value, decrement, zero flag).

Verification
REQ-032 ADD a=5,b=7,rd=3 at E0 -> wb_valid after E2, wb_data=12, wb_rd=3, wb_zero=0, stallD high for 1 cycle.
REQ-033 MUL a=6,b=7,rd=9 at E0 -> stallD high 5 cycles, wb_valid after E6, wb_data=42; id_valid held during stall is not accepted early.
REQ-034 SUB a=4,b=4 -> wb_data=0, wb_zero=1; then MUL presented in the DONE cycle -> accepted, no bubble.
REQ-035 MUL accepted, flush 2 cycles later -> no wb_valid, stallD low next cycle, next ADD completes normally.
REQ-036 rst low 3 cycles into MUL -> all outputs at reset values immediately; after release no spurious wb_valid.
REQ-037 funct3 illegal with id_valid -> no stall, no wb_valid, state stays IDLE.
